// File: rtl/i2s_pkg.sv
// Shared sizing and TUSER layout for the i2s_in lane merge path.
// The lane index sits in the low nibble of TUSER and the destination FPGA index in the high nibble.
package i2s_pkg;

    localparam int NUM_PORTS      = 16;
    localparam int DATA_W         = 32;

    localparam int TUSER_W        = 8;
    localparam int TUSER_LANE_LSB = 0;
    localparam int TUSER_LANE_W   = 4;
    localparam int TUSER_DST_LSB  = 4;
    localparam int TUSER_DST_W    = 4;

    function automatic logic [TUSER_W-1:0] make_tuser(
        input logic [TUSER_DST_W-1:0]  dst,
        input logic [TUSER_LANE_W-1:0] lane
    );
        logic [TUSER_W-1:0] u;
        u = '0;
        u[TUSER_DST_LSB  +: TUSER_DST_W]  = dst;
        u[TUSER_LANE_LSB +: TUSER_LANE_W] = lane;
        return u;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority encoder: the search starts one lane past ptr and wraps around.
// Purely combinational (zero latency); there is no backpressure, so the caller qualifies the grant.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    always_comb begin
        int cand;
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr) + 1 + i) % N;
            if (!vld && req[cand]) begin
                vld       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/i2s_in_arbiter.sv
// Merges the per-lane i2s_in words into one stream through a one-word hold per lane and round-robin arbitration.
// Capture-to-tvalid takes at least 2 cycles; the output register stalls on tready, and lanes overwrite their hold (flagging overflow).
module i2s_in_arbiter #(
    parameter int NUM_PORTS = i2s_pkg::NUM_PORTS,
    parameter int DATA_W    = i2s_pkg::DATA_W
) (
    input  logic                                    mclki,
    input  logic                                    arst_n,
    input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_W-1:0]             s_axis_tdata,
    input  logic [NUM_PORTS-1:0]                    s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                    i_enable,
    input  logic [i2s_pkg::TUSER_DST_W*NUM_PORTS-1:0] i_dst_fpga_index,
    output logic                                    m_axis_tvalid,
    input  logic                                    m_axis_tready,
    output logic [DATA_W-1:0]                       m_axis_tdata,
    output logic                                    m_axis_tlast,
    output logic [i2s_pkg::TUSER_W-1:0]             m_axis_tuser,
    output logic [NUM_PORTS-1:0]                    o_overflow,
    input  logic [NUM_PORTS-1:0]                    i_overflow_clr
);
    import i2s_pkg::*;

    localparam int IDX_W = $clog2(NUM_PORTS);

    // Reset asserts asynchronously but releases only on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge mclki or negedge arst_n) begin
        if (!arst_n) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [DATA_W-1:0]    hold_dat [NUM_PORTS];
    logic [NUM_PORTS-1:0] hold_last;
    logic [NUM_PORTS-1:0] hold_full;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic [NUM_PORTS-1:0] take;
    logic [NUM_PORTS-1:0] cap;
    logic [NUM_PORTS-1:0] ovf_set;
    logic [IDX_W-1:0]     last_grant;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 gnt_vld;
    logic                 load;

    // A lane being disabled this cycle is not offered, since its hold is about to be discarded.
    assign req     = hold_full & i_enable;
    assign load    = gnt_vld && (!m_axis_tvalid || m_axis_tready);
    assign take    = gnt & {NUM_PORTS{load}};
    assign cap     = s_axis_tvalid & i_enable;
    assign ovf_set = cap & hold_full & ~take;

    rr_arbiter #(
        .N     (NUM_PORTS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (req),
        .ptr (last_grant),
        .gnt (gnt),
        .idx (gnt_idx),
        .vld (gnt_vld)
    );

    always_ff @(posedge mclki or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= '0;
            hold_last <= '0;
            for (int k = 0; k < NUM_PORTS; k++) hold_dat[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!i_enable[k]) begin
                    hold_full[k] <= 1'b0;
                end else if (cap[k]) begin
                    hold_full[k] <= 1'b1;
                    hold_dat[k]  <= s_axis_tdata[k*DATA_W +: DATA_W];
                    hold_last[k] <= s_axis_tlast[k];
                end else if (take[k]) begin
                    hold_full[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge mclki or negedge rst_n) begin
        if (!rst_n) o_overflow <= '0;
        else        o_overflow <= ovf_set | (o_overflow & ~i_overflow_clr);
    end

    always_ff @(posedge mclki or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            last_grant    <= IDX_W'(NUM_PORTS - 1);
        end else if (load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= hold_dat[gnt_idx];
            m_axis_tlast  <= hold_last[gnt_idx];
            m_axis_tuser  <= make_tuser(i_dst_fpga_index[gnt_idx*TUSER_DST_W +: TUSER_DST_W],
                                        TUSER_LANE_W'(gnt_idx));
            last_grant    <= gnt_idx;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_in_arbiter.sv
// Scoreboard bench for i2s_in_arbiter: expected beats are queued as stimulus is driven, observed beats are queued by a monitor.
module tb_i2s_in_arbiter;

    localparam int NP = 16;
    localparam int DW = 32;

    logic              mclki = 1'b0;
    logic              arst_n = 1'b0;
    logic [NP-1:0]     s_axis_tvalid;
    logic [NP*DW-1:0]  s_axis_tdata;
    logic [NP-1:0]     s_axis_tlast;
    logic [NP-1:0]     i_enable;
    logic [4*NP-1:0]   i_dst_fpga_index;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tlast;
    logic [7:0]        m_axis_tuser;
    logic [NP-1:0]     o_overflow;
    logic [NP-1:0]     i_overflow_clr;

    i2s_in_arbiter #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
        .mclki            (mclki),
        .arst_n           (arst_n),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .i_enable         (i_enable),
        .i_dst_fpga_index (i_dst_fpga_index),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .o_overflow       (o_overflow),
        .i_overflow_clr   (i_overflow_clr)
    );

    always #5 mclki = ~mclki;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        logic [7:0]    u;
        int            cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;

    always @(posedge mclki) cyc <= cyc + 1;

    always @(negedge mclki) begin
        if (arst_n && m_axis_tvalid && m_axis_tready)
            obs_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, cyc});
    end

    task automatic tick();
        @(posedge mclki);
        #1;
    endtask

    task automatic idle();
        s_axis_tvalid = '0;
    endtask

    task automatic set_word(input int k, input logic [DW-1:0] d, input logic l, input logic [3:0] dst);
        s_axis_tvalid[k]          = 1'b1;
        s_axis_tdata[k*DW +: DW]  = d;
        s_axis_tlast[k]           = l;
        i_dst_fpga_index[k*4 +: 4] = dst;
    endtask

    task automatic push_exp(input int k, input logic [DW-1:0] d, input logic l, input logic [3:0] dst);
        exp_q.push_back('{d, l, {dst, 4'(k)}, 0});
    endtask

    task automatic wait_beats(input int n);
        for (int w = 0; w < 60; w++) begin
            if (obs_q.size() >= n) break;
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        arst_n = 1'b0;
        repeat (2) tick();
        arst_n = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== 8'h00) begin failures++; $display("FAIL reset_tuser: got %h want 00", m_axis_tuser); end
        checks++; if (o_overflow !== '0) begin failures++; $display("FAIL reset_overflow: got %h want 0", o_overflow); end
    endtask

    task automatic test_single();
        beat_t e, o;
        m_axis_tready = 1'b1;
        set_word(3, 32'hA5A5_0003, 1'b1, 4'd5);
        push_exp(3, 32'hA5A5_0003, 1'b1, 4'd5);
        tick();
        idle();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL single_early: tvalid got %b want 0 one cycle after strobe", m_axis_tvalid); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL single_latency: tvalid got %b want 1 two cycles after strobe", m_axis_tvalid); end
        wait_beats(1);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL single_count: got %0d beats want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL single_beat: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_all_lanes();
        beat_t e, o;
        int    span;
        apply_reset();
        m_axis_tready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            set_word(k, 32'hD000_0000 | DW'(k), (k == NP - 1), 4'(15 - k));
            push_exp(k, 32'hD000_0000 | DW'(k), (k == NP - 1), 4'(15 - k));
        end
        tick();
        idle();
        wait_beats(NP);
        checks++; if (obs_q.size() != NP) begin failures++; $display("FAIL all_count: got %0d beats want %0d", obs_q.size(), NP); end
        span = (obs_q.size() == NP) ? obs_q[NP-1].cyc - obs_q[0].cyc : -1;
        checks++; if (span != NP - 1) begin failures++; $display("FAIL all_consecutive: span %0d cycles want %0d", span, NP - 1); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL all_beat: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        checks++; if (o_overflow !== '0) begin failures++; $display("FAIL all_overflow: got %h want 0", o_overflow); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        beat_t e, o;
        m_axis_tready = 1'b0;
        set_word(0, 32'h0000_00E0, 1'b0, 4'd1);
        push_exp(0, 32'h0000_00E0, 1'b0, 4'd1);
        tick(); idle(); tick(); tick();
        set_word(7, 32'h0000_007A, 1'b0, 4'd2);
        tick(); idle(); tick(); tick();
        set_word(7, 32'h0000_007B, 1'b1, 4'd2);
        push_exp(7, 32'h0000_007B, 1'b1, 4'd2);
        tick(); idle();
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h0000_00E0 || m_axis_tuser !== 8'h10) begin
                failures++; $display("FAIL stall_hold: got %b/%h/%h want 1/000000e0/10", m_axis_tvalid, m_axis_tdata, m_axis_tuser);
            end
            tick();
        end
        checks++; if (o_overflow !== 16'h0080) begin failures++; $display("FAIL stall_overflow: got %h want 0080", o_overflow); end
        m_axis_tready = 1'b1;
        wait_beats(2);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL stall_count: got %0d beats want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL stall_beat: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        checks++; if (o_overflow !== 16'h0080) begin failures++; $display("FAIL overflow_sticky: got %h want 0080", o_overflow); end
        i_overflow_clr[7] = 1'b1;
        tick();
        i_overflow_clr = '0;
        checks++; if (o_overflow !== '0) begin failures++; $display("FAIL overflow_clear: got %h want 0", o_overflow); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_same_cycle();
        beat_t e, o;
        m_axis_tready = 1'b1;
        set_word(2, 32'h0000_002A, 1'b0, 4'd3);
        push_exp(2, 32'h0000_002A, 1'b0, 4'd3);
        tick();
        set_word(2, 32'h0000_002B, 1'b1, 4'd3);
        push_exp(2, 32'h0000_002B, 1'b1, 4'd3);
        tick();
        idle();
        wait_beats(2);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL same_count: got %0d beats want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL same_beat: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        checks++; if (o_overflow !== '0) begin failures++; $display("FAIL same_overflow: got %h want 0", o_overflow); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_enable();
        beat_t e, o;
        m_axis_tready = 1'b1;
        i_enable[9] = 1'b0;
        set_word(9, 32'h0000_009A, 1'b0, 4'd4);
        tick(); idle();
        repeat (6) tick();
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL disabled_beat: got %0d beats want 0", obs_q.size()); end
        checks++; if (o_overflow !== '0) begin failures++; $display("FAIL disabled_overflow: got %h want 0", o_overflow); end
        i_enable[9] = 1'b1;
        m_axis_tready = 1'b0;
        set_word(0, 32'h0000_00E1, 1'b0, 4'd6);
        push_exp(0, 32'h0000_00E1, 1'b0, 4'd6);
        tick(); idle(); tick(); tick();
        set_word(9, 32'h0000_009B, 1'b0, 4'd4);
        tick(); idle(); tick();
        i_enable[9] = 1'b0;
        tick();
        i_enable[9] = 1'b1;
        m_axis_tready = 1'b1;
        wait_beats(1);
        repeat (3) tick();
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL discard_count: got %0d beats want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL discard_beat: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        m_axis_tready = 1'b0;
        set_word(1, 32'h0000_001C, 1'b1, 4'd7);
        tick(); idle(); tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL midreset_pre: tvalid got %b want 1", m_axis_tvalid); end
        @(negedge mclki);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0 || m_axis_tuser !== 8'h00 || o_overflow !== '0) begin
            failures++; $display("FAIL midreset_async: got %b/%h/%b/%h/%h want all 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, o_overflow);
        end
        tick();
        arst_n = 1'b1;
        exp_q.delete(); obs_q.delete();
        repeat (3) tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL midreset_discard: tvalid got %b want 0", m_axis_tvalid); end
        m_axis_tready = 1'b1;
        set_word(1, 32'h0000_0011, 1'b0, 4'd8);
        set_word(4, 32'h0000_0044, 1'b1, 4'd9);
        push_exp(1, 32'h0000_0011, 1'b0, 4'd8);
        push_exp(4, 32'h0000_0044, 1'b1, 4'd9);
        tick(); idle();
        wait_beats(2);
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL midreset_count: got %0d beats want 2", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.d !== e.d || o.l !== e.l || o.u !== e.u) begin
                failures++; $display("FAIL midreset_order: got %h/%b/%h want %h/%b/%h", o.d, o.l, o.u, e.d, e.l, e.u);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_axis_tvalid    = '0;
        s_axis_tdata     = '0;
        s_axis_tlast     = '0;
        i_enable         = '1;
        i_dst_fpga_index = '0;
        i_overflow_clr   = '0;
        m_axis_tready    = 1'b0;
        test_reset();
        test_single();
        test_all_lanes();
        test_stall();
        test_same_cycle();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_in_arbiter.md
I2S_IN_ARBITER -- requirements
Module: i2s_in_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 16, number of i2s_in lanes merged.
REQ-002 Parameter DATA_W, default 32, sample word width per lane.
REQ-003 mclki  input  1  sole clock, 24.576 MHz; all logic is single-clock-domain on it.
REQ-004 arst_n  input  1  asynchronous active-low reset.
REQ-005 s_axis_tvalid  input  NUM_PORTS  per-lane word strobe from i2s_in (no backpressure).
REQ-006 s_axis_tdata  input  NUM_PORTS*DATA_W  per-lane word, lane k at bits [k*DATA_W +: DATA_W].
REQ-007 s_axis_tlast  input  NUM_PORTS  per-lane last word of TDM frame.
REQ-008 i_enable  input  NUM_PORTS  lane enable.
REQ-009 i_dst_fpga_index  input  4*NUM_PORTS  destination FPGA index per lane.
REQ-010 m_axis_tvalid / m_axis_tready  output / input  1 / 1  merged stream handshake.
REQ-011 m_axis_tdata  output  DATA_W  granted word.
REQ-012 m_axis_tlast  output  1  copy of the granted word's s_axis_tlast.
REQ-013 m_axis_tuser  output  8  {dst_fpga_index[3:0], lane[3:0]} of granted word.
REQ-014 o_overflow  output  NUM_PORTS  sticky per-lane overflow flag.
REQ-015 i_overflow_clr  input  NUM_PORTS  per-lane overflow clear, one-cycle pulse.

Function
REQ-016 Each lane has a one-entry holding register (data, last, full flag).
REQ-017 On s_axis_tvalid[k] with i_enable[k]=1, the word is captured into hold[k]; with i_enable[k]=0 it is dropped, no flag set.
REQ-018 Capture into a full hold[k] not granted that cycle overwrites it and sets o_overflow[k]; capture into a hold[k] being granted the same cycle is accepted without overflow.
REQ-019 Clearing i_enable[k] discards hold[k] on the next clock edge.
REQ-020 Grant occurs when the output register is empty or m_axis_tvalid&m_axis_tready this cycle, and at least one hold is full.
REQ-021 Arbitration is word-granular round robin: search starts at lane (last_grant+1) mod NUM_PORTS; after reset search starts at lane 0.
REQ-022 Granted word loads the output register at the grant edge; capture-to-m_axis_tvalid latency is 2 cycles minimum.
REQ-023 m_axis_tvalid, tdata, tlast, tuser are registered and remain stable while tvalid=1 and tready=0.
REQ-024 Sustained throughput is one word per cycle with tready=1; any lane is served within NUM_PORTS grants.
REQ-025 i_overflow_clr[k] clears o_overflow[k]; a simultaneous set wins over clear.
REQ-026 tuser dst_fpga_index is sampled from i_dst_fpga_index at grant time.

Reset
REQ-027 arst_n low: all holds empty, last_grant=NUM_PORTS-1, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser=0, o_overflow=0.
REQ-028 Reset assertion mid-transfer discards any pending word without producing a partial output beat; deassertion is synchronised to mclki inside the block.

Structure
REQ-029 NUM_PORTS, DATA_W, and TUSER field offsets reside in shared package i2s_pkg.
REQ-030 Round-robin priority encoder is sub-module rr_arbiter (request vector, pointer in, one-hot grant and index out).

Verification
REQ-031 Lane 3 single word 0xA5A5_0003, tlast=1, dst=5, tready=1 -> one beat after 2 cycles, tuser=0x53, tlast=1.
REQ-032 All 16 lanes capture simultaneously, tready=1 -> 16 consecutive beats, lane order 0..15, no overflow.
REQ-033 tready=0 for 20 cycles, lane 7 pulses twice -> o_overflow[7]=1, second word delivered after tready=1, output held stable during stall.
REQ-034 Lane 2 word arrives in the same cycle hold[2] is granted -> both words delivered, o_overflow[2]=0.
REQ-035 i_enable[9]=0, lane 9 pulses -> no beat; enable dropped with hold[9] full -> word discarded.
REQ-036 arst_n pulsed low with m_axis_tvalid=1 -> all outputs 0 asynchronously, next grant starts at lane 0.
